// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lane/state types and helpers for the traffic request front end
// Purpose: lane and FSM enumerations plus the lane-to-one-hot helper used by
// the request controller. No ports (package).
package traffic_pkg;

  typedef enum logic [1:0] {
    LANE_A = 2'd0,
    LANE_B = 2'd1,
    LANE_C = 2'd2,
    LANE_D = 2'd3
  } lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } req_state_t;

  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    lane_onehot = 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - per-lane sensor qualifier producing a single accept pulse
// Purpose: counts consecutive high samples of one raw sensor and fires a
// one-cycle accept event in the cycle the count reaches DEBOUNCE_CYCLES.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   sensor - raw sensor, synchronous to clk
//   accept - high for the one cycle whose edge completes qualification
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] count;

  // Counter saturates at LIMIT so a held sensor cannot re-fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!sensor) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  // Event coincides with the edge that moves the counter onto LIMIT, so the
  // pending bit can be registered on that same edge.
  assign accept = sensor && (count == LIMIT - CW'(1));

endmodule

// File: rtl/traffic_request_ctrl.sv
// rtl/traffic_request_ctrl.sv - debounced lane requests with round-robin switch_to arbitration
// Purpose: latches qualified sensor events as pending requests and issues one
// switch_to_* request at a time, held until light_en confirms the lane.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   sensor_a..sensor_d    - raw vehicle sensors
//   light_en[3:0]         - current green lane (one-hot, 0 = all red)
//   switch_to_a..d        - registered lane request, at most one high
//   pending[3:0]          - latched unserved requests
//   timeout_err           - one-cycle pulse when a request is abandoned
module traffic_request_ctrl
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int MIN_GREEN_CYCLES = 8,
  parameter int REQ_TIMEOUT      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       sensor_c,
  input  logic       sensor_d,
  input  logic [3:0] light_en,
  output logic       switch_to_a,
  output logic       switch_to_b,
  output logic       switch_to_c,
  output logic       switch_to_d,
  output logic [3:0] pending,
  output logic       timeout_err
);

  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam int HW = $clog2(MIN_GREEN_CYCLES + 1);

  req_state_t    state, state_n;
  lane_t         sel, sel_n;
  lane_t         last, last_n;
  logic [3:0]    req_q, req_n;
  logic [3:0]    pending_n;
  logic          timeout_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;

  logic [3:0]    accept;
  logic [3:0]    green;
  logic [3:0]    cand;
  logic [3:0]    clr;
  logic          found;
  logic [1:0]    pick;
  logic [1:0]    probe;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .rst(rst), .sensor(sensor_a), .accept(accept[0]));
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .rst(rst), .sensor(sensor_b), .accept(accept[1]));
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
    .clk(clk), .rst(rst), .sensor(sensor_c), .accept(accept[2]));
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .clk(clk), .rst(rst), .sensor(sensor_d), .accept(accept[3]));

  // Multi-hot light_en is meaningless from the controller; treat it as all red.
  assign green = ((light_en & (light_en - 4'd1)) == 4'd0) ? light_en : 4'd0;
  assign cand  = pending & ~green;

  // Round-robin search starting just after the last served lane; the
  // fourth probe wraps back onto last itself.
  always_comb begin
    found = 1'b0;
    pick  = last;
    probe = last;
    for (int k = 1; k <= 4; k++) begin
      probe = last + 2'(k);
      if (!found && cand[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    last_n    = last;
    req_n     = 4'd0;
    timeout_n = 1'b0;
    clr       = 4'd0;
    tcnt_n    = tcnt;
    hcnt_n    = hcnt;
    case (state)
      IDLE: begin
        clr    = green;
        tcnt_n = '0;
        hcnt_n = '0;
        if (found) begin
          sel_n   = lane_t'(pick);
          state_n = REQ;
          req_n   = lane_onehot(pick);
        end
      end
      REQ: begin
        tcnt_n = tcnt + TW'(1);
        if (green == lane_onehot(sel)) begin
          clr     = lane_onehot(sel);
          last_n  = sel;
          hcnt_n  = '0;
          state_n = HOLD;
        end else if (tcnt_n == TW'(REQ_TIMEOUT)) begin
          // Abandon but keep pending so the lane is retried after others.
          timeout_n = 1'b1;
          last_n    = sel;
          state_n   = IDLE;
        end else begin
          req_n = lane_onehot(sel);
        end
      end
      HOLD: begin
        hcnt_n = hcnt + HW'(1);
        if (hcnt_n == HW'(MIN_GREEN_CYCLES)) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // A fresh accept in the same cycle as a clear must survive.
    pending_n = (pending & ~clr) | accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sel         <= LANE_A;
      last        <= LANE_D;
      req_q       <= 4'd0;
      pending     <= 4'd0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
      hcnt        <= '0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      last        <= last_n;
      req_q       <= req_n;
      pending     <= pending_n;
      timeout_err <= timeout_n;
      tcnt        <= tcnt_n;
      hcnt        <= hcnt_n;
    end
  end

  assign switch_to_a = req_q[0];
  assign switch_to_b = req_q[1];
  assign switch_to_c = req_q[2];
  assign switch_to_d = req_q[3];

endmodule

// File: tb/tb_traffic_request_ctrl.sv
// tb/tb_traffic_request_ctrl.sv - self-checking bench for traffic_request_ctrl
`timescale 1ns/1ps
module tb_traffic_request_ctrl;

  localparam int DEB  = 4;
  localparam int MING = 8;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_a = 1'b0, sensor_b = 1'b0, sensor_c = 1'b0, sensor_d = 1'b0;
  logic [3:0] light_en = 4'd0;
  logic       switch_to_a, switch_to_b, switch_to_c, switch_to_d;
  logic [3:0] pending;
  logic       timeout_err;

  traffic_request_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .MIN_GREEN_CYCLES(MING), .REQ_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .sensor_a(sensor_a), .sensor_b(sensor_b), .sensor_c(sensor_c), .sensor_d(sensor_d),
    .light_en(light_en),
    .switch_to_a(switch_to_a), .switch_to_b(switch_to_b),
    .switch_to_c(switch_to_c), .switch_to_d(switch_to_d),
    .pending(pending), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run lengths per sensor, a mode word and a few counters.
  int         run[4];
  int         m_mode;   // 0 idle, 1 requesting, 2 holding
  int         m_sel, m_last, m_age, m_hold;
  logic [3:0] m_pend, m_sw;
  logic       m_to;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) run[i] = 0;
    m_mode = 0; m_sel = 0; m_last = 3; m_age = 0; m_hold = 0;
    m_pend = 4'd0; m_sw = 4'd0; m_to = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] s, acc, green, clr, cand;
    int pick;
    s = {sensor_d, sensor_c, sensor_b, sensor_a};
    green = (light_en == 4'd0 || $countones(light_en) == 1) ? light_en : 4'd0;
    acc = 4'd0;
    for (int i = 0; i < 4; i++) begin
      run[i] = s[i] ? ((run[i] <= DEB) ? run[i] + 1 : run[i]) : 0;
      acc[i] = (run[i] == DEB);
    end
    clr = 4'd0; m_to = 1'b0; m_sw = 4'd0;
    if (m_mode == 0) begin
      clr  = green;
      cand = m_pend & ~green;
      pick = -1;
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && cand[(m_last + k) % 4]) pick = (m_last + k) % 4;
      if (pick >= 0) begin
        m_sel = pick; m_mode = 1; m_age = 0; m_sw = 4'b1 << pick;
      end
    end else if (m_mode == 1) begin
      m_age++;
      if (green == (4'b1 << m_sel)) begin
        clr[m_sel] = 1'b1; m_last = m_sel; m_mode = 2; m_hold = 0;
      end else if (m_age == TMO) begin
        m_to = 1'b1; m_last = m_sel; m_mode = 0;
      end else begin
        m_sw = 4'b1 << m_sel;
      end
    end else begin
      m_hold++;
      if (m_hold == MING) m_mode = 0;
    end
    m_pend = (m_pend & ~clr) | acc;
  endtask

  always @(posedge clk) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Monitor state read by the directed sections.
  int         hi_cnt[4];
  int         to_pulses;
  logic       any_sw;
  int         order[$];
  logic [3:0] prev_sw = 4'd0;

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    to_pulses = 0;
    any_sw = 1'b0;
    order.delete();
  endtask

  always @(negedge clk) begin
    logic [3:0] sw;
    sw = {switch_to_d, switch_to_c, switch_to_b, switch_to_a};
    if (!rst) begin
      check("reset_sw", sw, 0);
      check("reset_pending", pending, 0);
      check("reset_timeout", timeout_err, 0);
      prev_sw = 4'd0;
    end else begin
      check("model_sw", sw, m_sw);
      check("model_pending", pending, m_pend);
      check("model_timeout", timeout_err, m_to);
      check("sw_at_most_one", ($countones(sw) <= 1) ? 1 : 0, 1);
      if (sw != 4'd0 && prev_sw == 4'd0)
        for (int i = 0; i < 4; i++) if (sw[i]) order.push_back(i);
      for (int i = 0; i < 4; i++) hi_cnt[i] += sw[i];
      if (timeout_err) to_pulses++;
      if (sw != 4'd0) any_sw = 1'b1;
      prev_sw = sw;
    end
  end

  function automatic logic [3:0] cur_sw();
    return {switch_to_d, switch_to_c, switch_to_b, switch_to_a};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(output logic [3:0] got, input int budget);
    int n;
    n = 0;
    got = 4'd0;
    while (got == 4'd0 && n < budget) begin
      step();
      got = cur_sw();
      n++;
    end
    if (got == 4'd0) check("wait_req_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b0; step(); rst = 1'b1; step();
  endtask

  function automatic int ord(input int k);
    return (order.size() > k) ? order[k] : -1;
  endfunction

  logic [3:0] got;

  initial begin
    clear_mon();
    #21 rst = 1'b1;
    repeat (3) step();
    check("idle_pending", pending, 0);
    check("idle_sw", cur_sw(), 0);
    check("idle_no_timeout", to_pulses, 0);

    // Single lane B, grant returned three cycles after the request rises.
    clear_mon();
    sensor_b = 1'b1;
    repeat (DEB) step();
    check("single_pending", pending, 4'b0010);
    sensor_b = 1'b0;
    wait_req(got, 20);
    check("single_lane", got, 4'b0010);
    step(); step();
    light_en = 4'b0010;
    step();
    check("single_b_high_cycles", hi_cnt[1], 3);
    check("single_pending_clr", pending, 0);
    clear_mon();
    repeat (MING) step();
    check("single_quiet", any_sw, 0);
    light_en = 4'd0;

    // Glitch on C never qualifies.
    clear_mon();
    sensor_c = 1'b1; repeat (3) step();
    sensor_c = 1'b0; step();
    sensor_c = 1'b1; repeat (3) step();
    sensor_c = 1'b0; repeat (6) step();
    check("glitch_pending", pending, 0);
    check("glitch_no_req", any_sw, 0);

    // Round robin from reset: A, C, D then back to A before B.
    pulse_reset();
    clear_mon();
    light_en = 4'd0;
    sensor_a = 1'b1; sensor_c = 1'b1; sensor_d = 1'b1;
    repeat (DEB) step();
    sensor_a = 1'b0; sensor_c = 1'b0; sensor_d = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_req(got, 40);
      light_en = got;
    end
    step();
    check("rr_count", order.size(), 3);
    check("rr_first", ord(0), 0);
    check("rr_second", ord(1), 2);
    check("rr_third", ord(2), 3);
    sensor_a = 1'b1; sensor_b = 1'b1;
    repeat (DEB) step();
    sensor_a = 1'b0; sensor_b = 1'b0;
    wait_req(got, 40);
    check("rr_wrap_to_a", got, 4'b0001);
    light_en = got;
    wait_req(got, 40);
    check("rr_then_b", got, 4'b0010);
    light_en = got;
    step();

    // Timeout on D, with B qualifying meanwhile.
    pulse_reset();
    clear_mon();
    light_en = 4'd0;
    sensor_d = 1'b1; repeat (DEB) step(); sensor_d = 1'b0;
    wait_req(got, 20);
    check("to_lane_d", got, 4'b1000);
    sensor_b = 1'b1; repeat (DEB) step(); sensor_b = 1'b0;
    for (int n = 0; n < 40 && to_pulses == 0; n++) step();
    check("to_d_high_cycles", hi_cnt[3], TMO);
    check("to_pulse_count", to_pulses, 1);
    check("to_pending_d_kept", pending[3], 1);
    wait_req(got, 20);
    check("to_b_first", got, 4'b0010);
    light_en = got;
    wait_req(got, 40);
    check("to_d_retry", got, 4'b1000);
    light_en = got;
    step();
    check("to_single_pulse", to_pulses, 1);
    check("to_all_served", pending, 0);

    // Lane already green: pending flashes up then clears with no request.
    pulse_reset();
    clear_mon();
    light_en = 4'b0001;
    sensor_a = 1'b1; repeat (DEB) step(); sensor_a = 1'b0;
    check("green_set_wins", pending, 4'b0001);
    step();
    check("green_cleared", pending, 0);
    repeat (4) step();
    check("green_no_req", any_sw, 0);

    // Reset during REQ drops the request immediately.
    light_en = 4'd0;
    sensor_c = 1'b1; repeat (DEB) step(); sensor_c = 1'b0;
    wait_req(got, 20);
    check("midrst_req_c", got, 4'b0100);
    #2 rst = 1'b0;
    #1 check("midrst_sw_drop", cur_sw(), 0);
    step();
    rst = 1'b1;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
      if ($urandom_range(0, 99) < 25) sensor_a = ~sensor_a;
      if ($urandom_range(0, 99) < 25) sensor_b = ~sensor_b;
      if ($urandom_range(0, 99) < 25) sensor_c = ~sensor_c;
      if ($urandom_range(0, 99) < 25) sensor_d = ~sensor_d;
      r = $urandom_range(0, 99);
      if (cur_sw() != 4'd0 && r < 35) light_en = cur_sw();
      else if (r < 45) light_en = 4'($urandom_range(0, 15));
      else if (r < 55) light_en = 4'd0;
      else if (r < 62) light_en = 4'b0001 << $urandom_range(0, 3);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_request_ctrl.md
# traffic_request_ctrl

Request-side front end for the four-way traffic light controller. It debounces four raw per-lane vehicle sensors and latches them as pending requests. A round-robin arbiter then drives exactly one `switch_to_*` request at a time into the controller and holds it until the controller's `light_en` confirms that lane is green. It sits between the sensor pads and the light controller, and it is the initiator end of the `switch_to_*` / `light_en` interface.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive high samples needed to accept a sensor (≥1).
- `MIN_GREEN_CYCLES`, default 8: cycles held in HOLD after a grant before the next request may issue (≥1).
- `REQ_TIMEOUT`, default 16: cycles in REQ without a grant before the request is abandoned (≥2).
- One clock; reset is asynchronous and active-low.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset, 1 = run).
- `sensor_a`…`sensor_d` input 1 each: raw vehicle sensors, already synchronous to `clk`.
- `light_en` input 4: current green lane from the controller; one-hot, bit0=A … bit3=D; 0 means all red.
- `switch_to_a`…`switch_to_d` output 1 each: lane request to the controller; at most one is high.
- `pending` output 4: latched, unserved requests; bit0=A.
- `timeout_err` output 1: one-cycle pulse when a request is abandoned.

## Operation
- **Debounce, per lane:**
  - A counter saturates at `DEBOUNCE_CYCLES` while the sensor is high and clears to 0 in any cycle the sensor is low.
  - An accept event fires once, in the cycle the counter reaches `DEBOUNCE_CYCLES`.
  - A sensor held high produces no further events; it must go low and re-qualify.
- **Pending bits:**
  - Set by an accept event.
  - Cleared when that lane is granted.
  - Cleared in IDLE if that lane is already green.
  - If set and clear occur in the same cycle, set wins.
- **Round-robin pointer `last` (2 bits):**
  - Holds the last lane granted or timed out.
  - Arbitration searches `last+1, last+2, …` modulo 4.
- **FSM states:**
  - **IDLE:** all `switch_to_*` = 0.
    - Candidates are `pending & ~light_en`.
    - If any candidate exists, latch `sel` = first candidate in round-robin order and go to REQ.
  - **REQ:** drive `switch_to_<sel>` = 1 and increment the timeout counter.
    - If `light_en == onehot(sel)`: clear `pending[sel]`, set `last` = `sel`, go to HOLD.
    - Else, if the counter reaches `REQ_TIMEOUT`: pulse `timeout_err`, set `last` = `sel`, keep `pending[sel]`, go to IDLE.
  - **HOLD:** all `switch_to_*` = 0. Count `MIN_GREEN_CYCLES`, then go to IDLE.
- **Illegal inputs:** a `light_en` that is not one-hot and not zero is treated as "no grant".
- **Illegal states:** any unused state encoding returns to IDLE.

## Timing
- **Reset (async assert, applies immediately):**
  - FSM = IDLE; `switch_to_*` = 0; `pending` = 0; `timeout_err` = 0.
  - All counters = 0; `last` = 3, so lane A has first priority.
- **Reset mid-operation:** any held request drops in the same instant; the controller sees no request.
- **Sensor to `pending`:** the sensor high in cycle 0 makes `pending` visible after the edge ending cycle `DEBOUNCE_CYCLES-1`.
- **`pending` to request:**
  - IDLE evaluates `pending` one cycle after it is set.
  - `switch_to_*` rises on the edge after that evaluation.
  - Total latency from sensor onset to request is `DEBOUNCE_CYCLES+1` cycles.
- **Grant:** sampled on each edge in REQ; `switch_to_*` falls on the edge that samples the grant.
- **HOLD:** lasts exactly `MIN_GREEN_CYCLES` cycles; the earliest next request is 1 cycle after HOLD exits.
- **Timeout:** the request is high for exactly `REQ_TIMEOUT` cycles; `timeout_err` is high for the following cycle only.
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Structure
- Shared package `traffic_pkg`:
  - `lane_t` enum: A=0, B=1, C=2, D=3.
  - `req_state_t` enum: IDLE, REQ, HOLD.
  - `lane_onehot()` function.
- Sub-module `sensor_debounce`: one instance per lane, parameterised by `DEBOUNCE_CYCLES`; outputs the single-cycle accept event.
- Arbiter, FSM and pending register stay in the top level.

## Test plan
- **Reset and idle:** reset low for 20 ns, then released with all sensors 0 → all `switch_to_*` = 0, `pending` = 0, `timeout_err` never pulses.
- **Single lane:**
  - Stimulus: `sensor_b` high for 4 cycles; bench returns `light_en` = 4'b0010 three cycles after `switch_to_b` rises.
  - Required: `pending` = 4'b0010; `switch_to_b` high for exactly 3 cycles; `pending` returns to 0; no request for 8 cycles.
- **Glitch rejection:** `sensor_c` high 3 cycles, low 1, high 3 → `pending` stays 0 and no request issues.
- **Round-robin:**
  - Stimulus: A, C and D qualify together; each grant is returned 1 cycle after its request.
  - Required: request order A, C, D; the next arbitration after D starts at A.
- **Timeout:**
  - Stimulus: `sensor_d` qualifies and `light_en` is held at 0.
  - Required: `switch_to_d` high 16 cycles; `timeout_err` pulses once; `pending[3]` stays 1; D is re-requested only after other pending lanes.
- **Already green and mid-request reset:**
  - `sensor_a` qualifies while `light_en` = 4'b0001 → `pending[0]` clears in IDLE and no request issues.
  - `rst` asserted during REQ → `switch_to_*` drops to 0 immediately.
